// File: rtl/piano_pkg.sv
// Shared types and helpers for the key sequence recorder.
package piano_pkg;

  localparam int unsigned CLK_HZ = 50_000_000;

  // Width of a key ID able to hold 0 (rest) through num_keys.
  function automatic int unsigned key_id_width(input int unsigned num_keys);
    return (num_keys == 0) ? 1 : $clog2(num_keys + 1);
  endfunction

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RECORD    = 2'd1,
    PLAY_LOAD = 2'd2,
    PLAY_HOLD = 2'd3
  } rec_state_t;

  // Reference segment layout at the default sizes (12 keys, 16-bit duration).
  // The recorder builds its own layout from its parameters with the same field
  // order: key_id in the upper bits, duration in the lower bits.
  typedef struct packed {
    logic [3:0]  key_id;
    logic [15:0] duration;
  } segment_t;

endpackage

// File: rtl/ms_tick_gen.sv
// Duration tick generator: one-cycle pulse every TICK_CYCLES clocks.
// A synchronous clear restarts the period so the first tick lands
// TICK_CYCLES cycles after the clear.
module ms_tick_gen #(
  parameter int unsigned TICK_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CNT_W = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == CNT_LAST);

  // Next count: wrap on terminal count, restart on clear.
  always_comb begin
    cnt_d = cnt_q + CNT_W'(1);
    if (clr || tick) begin
      cnt_d = '0;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/key_sequence_recorder.sv
// Key sequence recorder: captures the scanner key stream as {key_id, duration}
// segments in an on-chip RAM and replays them as a key-ID stream.
// Build option KEY_SEQ_LOOP_EN: playback wraps to the first entry after the last
// one and only ends on play_stop. Without it, playback ends after the last entry.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for rec_start / play_start
// RECORD    | timing the current segment, writing finished ones
// PLAY_LOAD | reading entry[idx] from the buffer
// PLAY_HOLD | presenting entry[idx] key ID for its duration in ticks
module key_sequence_recorder
  import piano_pkg::*;
#(
  parameter  int unsigned NUM_KEYS    = 12,
  parameter  int unsigned MAX_EVENTS  = 64,
  parameter  int unsigned TICK_CYCLES = CLK_HZ / 1000,
  parameter  int unsigned DUR_W       = 16,
  localparam int unsigned KW          = key_id_width(NUM_KEYS),
  localparam int unsigned CW          = $clog2(MAX_EVENTS + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [KW-1:0] active_key_id,
  input  logic          key_is_pressed,
  input  logic          rec_start,
  input  logic          rec_stop,
  input  logic          play_start,
  input  logic          play_stop,
  output logic [KW-1:0] play_key_id,
  output logic          play_active,
  output logic          recording,
  output logic          buf_full,
  output logic [CW-1:0] event_count
);

  localparam int unsigned AW = (MAX_EVENTS > 1) ? $clog2(MAX_EVENTS) : 1;
  localparam logic [CW-1:0]    MAX_CNT = CW'(MAX_EVENTS);
  localparam logic [DUR_W-1:0] DUR_MAX = '1;

  typedef struct packed {
    logic [KW-1:0]    key_id;
    logic [DUR_W-1:0] duration;
  } seg_t;

  rec_state_t       state_q, state_d;
  logic [KW-1:0]    cur_id_q, cur_id_d;
  logic [DUR_W-1:0] dur_q, dur_d;
  logic [CW-1:0]    count_q, count_d;
  logic [CW-1:0]    idx_q, idx_d;
  logic             wr_pend_q, wr_pend_d;
  seg_t             wr_seg_q, wr_seg_d;
  logic             key_vld_q, key_vld_d;

  seg_t             mem [MAX_EVENTS];
  seg_t             rd_data_q;
  logic             ram_we, ram_re;
  logic [AW-1:0]    ram_addr;

  logic             tick, tick_clr, seg_restart;
  logic [KW-1:0]    seg_id;
  logic [DUR_W-1:0] dur_inc;
  logic             wr_en, fill_last, hold_done, last_entry, play_ok;

  ms_tick_gen #(
    .TICK_CYCLES (TICK_CYCLES)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (tick_clr),
    .tick  (tick)
  );

  // The tick period restarts on every state change and on every new segment,
  // so a glitch shorter than one period can never collect a tick.
  assign tick_clr = (state_d != state_q) || seg_restart;

  // Shared conditions used by both the next-state and the datapath logic.
  always_comb begin
    seg_id     = key_is_pressed ? active_key_id : '0;
    dur_inc    = (tick && (dur_q != DUR_MAX)) ? dur_q + DUR_W'(1) : dur_q;
    wr_en      = wr_pend_q && (count_q != MAX_CNT);
    fill_last  = wr_en && (count_q == (MAX_CNT - CW'(1)));
    hold_done  = tick && ((dur_q + DUR_W'(1)) == rd_data_q.duration);
    last_entry = ((idx_q + CW'(1)) == count_q);
    play_ok    = play_start && (count_q != '0);
  end

  // State register plus datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cur_id_q  <= '0;
      dur_q     <= '0;
      count_q   <= '0;
      idx_q     <= '0;
      wr_pend_q <= 1'b0;
      wr_seg_q  <= '0;
      key_vld_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cur_id_q  <= cur_id_d;
      dur_q     <= dur_d;
      count_q   <= count_d;
      idx_q     <= idx_d;
      wr_pend_q <= wr_pend_d;
      wr_seg_q  <= wr_seg_d;
      key_vld_q <= key_vld_d;
    end
  end

  // Next-state logic. Commands in IDLE wait one cycle while the segment
  // flushed by rec_stop is still being written.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!wr_pend_q) begin
          if (rec_start) begin
            state_d = RECORD;
          end else if (play_ok) begin
            state_d = PLAY_LOAD;
          end
        end
      end
      RECORD: begin
        if (rec_stop || fill_last) begin
          state_d = IDLE;
        end
      end
      PLAY_LOAD: begin
        state_d = play_stop ? IDLE : PLAY_HOLD;
      end
      PLAY_HOLD: begin
        if (play_stop) begin
          state_d = IDLE;
        end else if (hold_done) begin
`ifdef KEY_SEQ_LOOP_EN
          state_d = PLAY_LOAD;
`else
          state_d = last_entry ? IDLE : PLAY_LOAD;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: segment timing and write queueing while recording,
  // index and hold timing while playing.
  always_comb begin
    cur_id_d    = cur_id_q;
    dur_d       = dur_q;
    count_d     = wr_en ? count_q + CW'(1) : count_q;
    idx_d       = idx_q;
    wr_pend_d   = 1'b0;
    wr_seg_d    = wr_seg_q;
    key_vld_d   = key_vld_q;
    seg_restart = 1'b0;
    case (state_q)
      IDLE: begin
        if (!wr_pend_q && rec_start) begin
          count_d  = '0;
          cur_id_d = seg_id;
          dur_d    = '0;
        end else if (!wr_pend_q && play_ok) begin
          idx_d     = '0;
          key_vld_d = 1'b0;
        end
      end
      RECORD: begin
        if (rec_stop) begin
          if (dur_inc != '0) begin
            wr_pend_d = 1'b1;
            wr_seg_d  = '{key_id: cur_id_q, duration: dur_inc};
          end
        end else if (seg_id != cur_id_q) begin
          if (dur_inc != '0) begin
            wr_pend_d = 1'b1;
            wr_seg_d  = '{key_id: cur_id_q, duration: dur_inc};
          end
          cur_id_d    = seg_id;
          dur_d       = '0;
          seg_restart = 1'b1;
        end else if (dur_inc == DUR_MAX) begin
          // Long note: emit a full-length segment and keep timing the same key.
          wr_pend_d = 1'b1;
          wr_seg_d  = '{key_id: cur_id_q, duration: DUR_MAX};
          dur_d     = '0;
        end else begin
          dur_d = dur_inc;
        end
        if (fill_last) begin
          wr_pend_d = 1'b0;
        end
      end
      PLAY_LOAD: begin
        dur_d     = '0;
        key_vld_d = !play_stop;
      end
      PLAY_HOLD: begin
        if (play_stop) begin
          key_vld_d = 1'b0;
        end else if (hold_done) begin
          dur_d = '0;
          if (last_entry) begin
`ifdef KEY_SEQ_LOOP_EN
            idx_d = '0;
`else
            key_vld_d = 1'b0;
`endif
          end else begin
            idx_d = idx_q + CW'(1);
          end
        end else if (tick) begin
          dur_d = dur_q + DUR_W'(1);
        end
      end
      default: ;
    endcase
  end

  // Outputs and buffer port control.
  always_comb begin
    play_active = (state_q == PLAY_LOAD) || (state_q == PLAY_HOLD);
    recording   = (state_q == RECORD);
    buf_full    = (count_q == MAX_CNT);
    event_count = count_q;
    play_key_id = key_vld_q ? rd_data_q.key_id : '0;
    ram_we      = wr_en;
    ram_re      = (state_q == PLAY_LOAD);
    ram_addr    = wr_en ? count_q[AW-1:0] : idx_q[AW-1:0];
  end

  // Single-port segment buffer with registered read; contents survive
  // until the next recording overwrites them.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= wr_seg_q;
    end else if (ram_re) begin
      rd_data_q <= mem[ram_addr];
    end
  end

endmodule

// File: tb/tb_key_sequence_recorder.sv
// Scoreboard bench for key_sequence_recorder (TICK_CYCLES=10, DUR_W=4, MAX_EVENTS=4).
// Stored entries are observed through playback: the monitor cuts the replayed
// key stream into runs of constant key ID and compares each run with the queue.
// Run lengths skip the first PLAY_LOAD cycle; an entry of d ticks shows for
// 10*d cycles plus the following PLAY_LOAD cycle (none after the final entry),
// and consecutive entries with the same key merge into one run.
module tb_key_sequence_recorder;

  localparam int NUM_KEYS    = 12;
  localparam int MAX_EVENTS  = 4;
  localparam int TICK_CYCLES = 10;
  localparam int DUR_W       = 4;
  localparam int KW          = $clog2(NUM_KEYS + 1);
  localparam int CW          = $clog2(MAX_EVENTS + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [KW-1:0] active_key_id = '0;
  logic          key_is_pressed = 1'b0;
  logic          rec_start = 1'b0, rec_stop = 1'b0;
  logic          play_start = 1'b0, play_stop = 1'b0;
  logic [KW-1:0] play_key_id;
  logic          play_active, recording, buf_full;
  logic [CW-1:0] event_count;

  key_sequence_recorder #(
    .NUM_KEYS    (NUM_KEYS),
    .MAX_EVENTS  (MAX_EVENTS),
    .TICK_CYCLES (TICK_CYCLES),
    .DUR_W       (DUR_W)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .active_key_id  (active_key_id),
    .key_is_pressed (key_is_pressed),
    .rec_start      (rec_start),
    .rec_stop       (rec_stop),
    .play_start     (play_start),
    .play_stop      (play_stop),
    .play_key_id    (play_key_id),
    .play_active    (play_active),
    .recording      (recording),
    .buf_full       (buf_full),
    .event_count    (event_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int id;
    int len;
  } run_t;

  run_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  int   seq_id[8];
  int   seq_len[8];
  int   seq_n = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic push_run(input int id, input int len);
    run_t r;
    r.id  = id;
    r.len = len;
    exp_q.push_back(r);
  endtask

  // Rest is driven with a non-zero key ID and pressed low.
  task automatic set_key(input int id);
    key_is_pressed = (id != 0);
    active_key_id  = (id != 0) ? KW'(id) : KW'(9);
  endtask

  task automatic add_seg(input int id, input int len);
    seq_id[seq_n]  = id;
    seq_len[seq_n] = len;
    seq_n++;
  endtask

  // rec_start together with the first segment, each segment held for its
  // length in cycles, then rec_stop, then a few cycles for the final write.
  task automatic run_record(input bit check_rec);
    @(negedge clk);
    rec_start = 1'b1;
    for (int i = 0; i < seq_n; i++) begin
      set_key(seq_id[i]);
      for (int c = 0; c < seq_len[i]; c++) begin
        @(negedge clk);
        if (rec_start) begin
          rec_start = 1'b0;
          if (check_rec) chk("recording_high", recording, 1);
        end
      end
    end
    rec_stop = 1'b1;
    @(negedge clk);
    rec_stop = 1'b0;
    set_key(0);
    repeat (3) @(negedge clk);
    seq_n = 0;
  endtask

  task automatic start_play();
    @(negedge clk);
    play_start = 1'b1;
    @(negedge clk);
    play_start = 1'b0;
  endtask

  task automatic wait_play_done();
    for (int i = 0; i < 1000 && play_active; i++) @(negedge clk);
    @(negedge clk);
    chk("play_end", play_active, 0);
    chk("runs_pending", exp_q.size(), 0);
    exp_q.delete();
  endtask

  // Monitor: build runs of constant play_key_id, compare each finished run.
  int mon_id = 0, mon_len = 0;
  bit mon_in_run = 0, mon_seen_first = 0;

  task automatic emit_run();
    run_t e;
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL run_unexpected: got id %0d len %0d, expected no run", mon_id, mon_len);
    end else begin
      e = exp_q.pop_front();
      chk("run_id", mon_id, e.id);
      chk("run_len", mon_len, e.len);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mon_in_run     = 0;
        mon_seen_first = 0;
      end else if (play_active) begin
        if (!mon_seen_first) begin
          mon_seen_first = 1;
        end else if (mon_in_run && int'(play_key_id) == mon_id) begin
          mon_len++;
        end else begin
          if (mon_in_run) emit_run();
          mon_id     = int'(play_key_id);
          mon_len    = 1;
          mon_in_run = 1;
        end
      end else begin
        if (mon_in_run) emit_run();
        mon_in_run     = 0;
        mon_seen_first = 0;
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_play_key_id", play_key_id, 0);
    chk("rst_play_active", play_active, 0);
    chk("rst_recording", recording, 0);
    chk("rst_buf_full", buf_full, 0);
    chk("rst_event_count", event_count, 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // play_start with an empty buffer is ignored
    start_play();
    chk("empty_play_active", play_active, 0);
    @(negedge clk);
    chk("empty_play_active_2", play_active, 0);
    chk("empty_recording", recording, 0);

    // rest 30 cycles, key 5 for 50 cycles -> {0,3},{5,5}
    add_seg(0, 30);
    add_seg(5, 50);
    run_record(1);
    chk("t1_count", event_count, 2);
    chk("t1_recording", recording, 0);
    chk("t1_buf_full", buf_full, 0);

`ifdef KEY_SEQ_LOOP_EN
    // looping playback: three passes, stopped 44 cycles into the third key-5 run
    push_run(0, 31); push_run(5, 51);
    push_run(0, 31); push_run(5, 51);
    push_run(0, 31); push_run(5, 44);
    start_play();
    repeat (239) @(negedge clk);
    play_stop = 1'b1;
    @(negedge clk);
    play_stop = 1'b0;
    chk("loop_stop_active", play_active, 0);
    chk("loop_stop_key", play_key_id, 0);
    wait_play_done();
`else
    push_run(0, 31);
    push_run(5, 50);
    start_play();
    wait_play_done();

    // key 3 held 200 cycles -> {3,15},{3,5}, replayed as one run of key 3
    add_seg(3, 200);
    run_record(0);
    chk("t2_count", event_count, 2);
    push_run(3, 201);
    start_play();
    wait_play_done();

    // 5-cycle glitch of key 7 between rests -> {0,3},{0,3}
    add_seg(0, 30);
    add_seg(7, 5);
    add_seg(0, 30);
    run_record(0);
    chk("t3_count", event_count, 2);
    push_run(0, 61);
    start_play();
    wait_play_done();

    // six keys of 2 ticks each: buffer fills after the 4th
    for (int k = 1; k <= 6; k++) add_seg(k, 20);
    run_record(0);
    chk("t4_count", event_count, 4);
    chk("t4_buf_full", buf_full, 1);
    chk("t4_recording", recording, 0);
    push_run(1, 21); push_run(2, 21); push_run(3, 21); push_run(4, 20);
    start_play();
    wait_play_done();

    // rec_start ignored in PLAY; play_stop mid-segment clears outputs next cycle
    push_run(1, 9);
    start_play();
    repeat (3) @(negedge clk);
    rec_start = 1'b1;
    @(negedge clk);
    rec_start = 1'b0;
    chk("t5_rec_ignored", recording, 0);
    chk("t5_still_playing", play_active, 1);
    repeat (5) @(negedge clk);
    play_stop = 1'b1;
    @(negedge clk);
    play_stop = 1'b0;
    chk("t5_stop_active", play_active, 0);
    chk("t5_stop_key", play_key_id, 0);
    wait_play_done();
    chk("t5_count_kept", event_count, 4);

    // asynchronous reset in the third segment of playback
    push_run(1, 21);
    push_run(2, 21);
    start_play();
    repeat (49) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_key", play_key_id, 0);
    chk("t6_rst_active", play_active, 0);
    chk("t6_rst_recording", recording, 0);
    chk("t6_rst_buf_full", buf_full, 0);
    chk("t6_rst_count", event_count, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_runs_pending", exp_q.size(), 0);
    chk("t6_count_after", event_count, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
